// File: rtl/rgb_serializer.sv
// Pixel FIFO that serialises buffered {r,g,b} entries into a byte stream with sop/eop framing.
// Define RGB_SERIALIZER_ALPHA_EN to append a constant 8'hFF alpha byte to every pixel.
module rgb_serializer #(
  parameter int unsigned DEPTH = 4,
  parameter bit          BGR   = 1'b0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [7:0]              r,
  input  logic [7:0]              g,
  input  logic [7:0]              b,
  input  logic                    vld,
  output logic                    rdy,
  output logic [7:0]              dat,
  output logic                    dat_vld,
  input  logic                    dat_rdy,
  output logic                    dat_sop,
  output logic                    dat_eop,
  output logic [$clog2(DEPTH):0]  cnt
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0] Full = CW'(DEPTH);

`ifdef RGB_SERIALIZER_ALPHA_EN
  typedef enum logic [1:0] {Ph0, Ph1, Ph2, Ph3} phase_e;
  localparam phase_e PhLast = Ph3;
`else
  typedef enum logic [1:0] {Ph0, Ph1, Ph2} phase_e;
  localparam phase_e PhLast = Ph2;
`endif

  logic [23:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  phase_e        phase_q, phase_d;
  logic          push, pop, xfer;
  logic [23:0]   head;

  // No pass-through when full: rdy depends only on the registered count.
  assign rdy     = (cnt_q != Full) && !rst;
  assign dat_vld = (cnt_q != '0);
  assign xfer    = dat_vld && dat_rdy;
  assign push    = vld && rdy;
  assign pop     = xfer && (phase_q == PhLast);
  assign head    = mem[rd_ptr_q];
  assign cnt     = cnt_q;

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    unique case ({push, pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_q] <= {r, g, b};
    end
  end

  // Byte-phase FSM: state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase_q <= Ph0;
    end else begin
      phase_q <= phase_d;
    end
  end

  // Byte-phase FSM: next state, advancing only on a byte transfer.
  always_comb begin
    phase_d = phase_q;
    if (xfer) begin
      case (phase_q)
        Ph0:     phase_d = Ph1;
        Ph1:     phase_d = Ph2;
`ifdef RGB_SERIALIZER_ALPHA_EN
        Ph2:     phase_d = Ph3;
        Ph3:     phase_d = Ph0;
`else
        Ph2:     phase_d = Ph0;
`endif
        default: phase_d = Ph0;
      endcase
    end
  end

  // Byte-phase FSM: outputs.
  always_comb begin
    dat     = 8'h00;
    dat_sop = 1'b0;
    dat_eop = 1'b0;
    if (dat_vld) begin
      dat_sop = (phase_q == Ph0);
      dat_eop = (phase_q == PhLast);
      case (phase_q)
        Ph0:     dat = BGR ? head[7:0] : head[23:16];
        Ph1:     dat = head[15:8];
        Ph2:     dat = BGR ? head[23:16] : head[7:0];
`ifdef RGB_SERIALIZER_ALPHA_EN
        Ph3:     dat = 8'hFF;
`endif
        default: dat = 8'h00;
      endcase
    end
  end

endmodule

// File: tb/tb_rgb_serializer.sv
// Bench for rgb_serializer: RGB and BGR instances share stimulus and are checked each cycle
// against a queue-based pixel model, plus directed byte-stream literals.
module tb_rgb_serializer;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned CW    = $clog2(DEPTH) + 1;
`ifdef RGB_SERIALIZER_ALPHA_EN
  localparam int NB = 4;
`else
  localparam int NB = 3;
`endif

  typedef logic [7:0] bq_t[$];

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [7:0]    r = 8'h00, g = 8'h00, b = 8'h00;
  logic          vld = 1'b0;
  logic          dat_rdy = 1'b0;

  logic          rdy0, dv0, sop0, eop0;
  logic [7:0]    dat0;
  logic [CW-1:0] cnt0;
  logic          rdy1, dv1, sop1, eop1;
  logic [7:0]    dat1;
  logic [CW-1:0] cnt1;

  rgb_serializer #(.DEPTH(DEPTH), .BGR(1'b0)) dut (
    .clk(clk), .rst(rst), .r(r), .g(g), .b(b), .vld(vld), .rdy(rdy0),
    .dat(dat0), .dat_vld(dv0), .dat_rdy(dat_rdy), .dat_sop(sop0), .dat_eop(eop0), .cnt(cnt0)
  );

  rgb_serializer #(.DEPTH(DEPTH), .BGR(1'b1)) dut_bgr (
    .clk(clk), .rst(rst), .r(r), .g(g), .b(b), .vld(vld), .rdy(rdy1),
    .dat(dat1), .dat_vld(dv1), .dat_rdy(dat_rdy), .dat_sop(sop1), .dat_eop(eop1), .cnt(cnt1)
  );

  always #5 clk = ~clk;

  int         vectors = 0;
  int         fails   = 0;
  logic [23:0] mq[$];
  int         ph = 0;
  bit         m_push;
  bq_t        out0, out1;
  bit         saw_full = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic timeout(input string name);
    vectors++;
    fails++;
    $display("FAIL %s: wait bound expired at %0t", name, $time);
  endtask

  function automatic logic [7:0] byte_of(input logic [23:0] p, input int k, input bit bgr);
    case (k)
      0:       return bgr ? p[7:0] : p[23:16];
      1:       return p[15:8];
      2:       return bgr ? p[23:16] : p[7:0];
      default: return 8'hFF;
    endcase
  endfunction

  // Pixel-level model: a queue of whole pixels plus a byte index into the head pixel.
  always @(posedge clk) begin
    if (rst) begin
      mq.delete();
      ph = 0;
    end else begin
      m_push = vld && (mq.size() < DEPTH);
      if (mq.size() != 0 && dat_rdy) begin
        if (ph == NB - 1) begin
          ph = 0;
          void'(mq.pop_front());
        end else begin
          ph++;
        end
      end
      if (m_push) mq.push_back({r, g, b});
    end
  end

  task automatic cmp_one(input int k, input logic rdy_a, input logic dv_a, input logic [7:0] dat_a,
                         input logic sop_a, input logic eop_a, input logic [CW-1:0] cnt_a);
    logic       ev;
    logic [7:0] ed;
    ev = !rst && (mq.size() != 0);
    ed = ev ? byte_of(mq[0], ph, k[0]) : 8'h00;
    check($sformatf("dut%0d.rdy", k), rdy_a, !rst && (mq.size() < DEPTH));
    check($sformatf("dut%0d.dat_vld", k), dv_a, ev);
    check($sformatf("dut%0d.dat", k), dat_a, ed);
    check($sformatf("dut%0d.sop", k), sop_a, ev && (ph == 0));
    check($sformatf("dut%0d.eop", k), eop_a, ev && (ph == NB - 1));
    check($sformatf("dut%0d.cnt", k), cnt_a, rst ? 0 : mq.size());
  endtask

  always @(negedge clk) begin
    cmp_one(0, rdy0, dv0, dat0, sop0, eop0, cnt0);
    cmp_one(1, rdy1, dv1, dat1, sop1, eop1, cnt1);
    if (dv0 && dat_rdy) out0.push_back(dat0);
    if (dv1 && dat_rdy) out1.push_back(dat1);
    if (cnt0 == CW'(DEPTH) && !rdy0) saw_full = 1'b1;
  end

  task automatic push_pixel(input logic [23:0] p);
    int   n;
    logic acc;
    n = 0;
    {r, g, b} = p;
    vld = 1'b1;
    forever begin
      @(negedge clk);
      acc = rdy0;
      @(posedge clk);
      #1;
      if (acc) break;
      n++;
      if (n > 200) begin
        timeout("push_wait");
        break;
      end
    end
    vld = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((dv0 || cnt0 != '0) && n < 500) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= 500) timeout("drain_wait");
  endtask

  task automatic check_bytes(input string name, input bq_t got, input bq_t exp);
    check({name, ".len"}, got.size(), exp.size());
    for (int i = 0; i < exp.size(); i++) begin
      if (i < got.size()) check($sformatf("%s[%0d]", name, i), got[i], exp[i]);
    end
  endtask

  task automatic clear_out();
    out0.delete();
    out1.delete();
  endtask

  initial begin
    bq_t e0, e1;
    logic [23:0] p;

    // Reset held with vld asserted.
    rst = 1'b1;
    vld = 1'b1;
    {r, g, b} = 24'hAABBCC;
    repeat (3) @(posedge clk);
    #1;
    check("rst_rdy", rdy0, 0);
    check("rst_dat_vld", dv0, 0);
    check("rst_cnt", cnt0, 0);
    rst = 1'b0;
    vld = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("post_rst_no_bytes", out0.size(), 0);

    // Single pixel.
    dat_rdy = 1'b1;
    clear_out();
    push_pixel(24'h112233);
    check("single_first_dat", dat0, 8'h11);
    check("single_first_sop", sop0, 1);
    drain();
    e0 = '{8'h11, 8'h22, 8'h33};
    e1 = '{8'h33, 8'h22, 8'h11};
`ifdef RGB_SERIALIZER_ALPHA_EN
    e0.push_back(8'hFF);
    e1.push_back(8'hFF);
`endif
    check_bytes("single_rgb", out0, e0);
    check_bytes("single_bgr", out1, e1);
    check("single_cnt_end", cnt0, 0);

    // Ramp stream of 16 pixels with r=g=b=i.
    clear_out();
    saw_full = 1'b0;
    e0.delete();
    e1.delete();
    for (int i = 0; i < 16; i++) begin
      p = {3{i[7:0]}};
      push_pixel(p);
      for (int k = 0; k < NB; k++) begin
        e0.push_back(byte_of(p, k, 1'b0));
        e1.push_back(byte_of(p, k, 1'b1));
      end
    end
    drain();
    check_bytes("ramp_rgb", out0, e0);
    check_bytes("ramp_bgr", out1, e1);
    check("ramp_saw_full", saw_full, 1);

    // Sink stall at PH1 with a full FIFO.
    clear_out();
    e0.delete();
    dat_rdy = 1'b0;
    for (int i = 0; i < 4; i++) begin
      p = {8'h40 + 8'(i), 8'h50 + 8'(i), 8'h60 + 8'(i)};
      push_pixel(p);
      for (int k = 0; k < NB; k++) e0.push_back(byte_of(p, k, 1'b0));
    end
    check("stall_cnt_full", cnt0, 4);
    check("stall_rdy_full", rdy0, 0);
    dat_rdy = 1'b1;
    @(posedge clk);
    #1;
    dat_rdy = 1'b0;
    {r, g, b} = 24'h707172;
    vld = 1'b1;
    for (int i = 0; i < 5; i++) begin
      check("stall_dat_g", dat0, 8'h50);
      check("stall_dat_vld", dv0, 1);
      check("stall_rdy", rdy0, 0);
      @(posedge clk);
      #1;
    end
    dat_rdy = 1'b1;
    @(posedge clk);
    #1;
    check("stall_resume_b", dat0, 8'h60);
    push_pixel(24'h707172);
    for (int k = 0; k < NB; k++) e0.push_back(byte_of(24'h707172, k, 1'b0));
    drain();
    check_bytes("stall_rgb", out0, e0);

    // BGR ordering.
    clear_out();
    push_pixel(24'hA0B0C0);
    drain();
    e0 = '{8'hA0, 8'hB0, 8'hC0};
    e1 = '{8'hC0, 8'hB0, 8'hA0};
`ifdef RGB_SERIALIZER_ALPHA_EN
    e0.push_back(8'hFF);
    e1.push_back(8'hFF);
`endif
    check_bytes("order_rgb", out0, e0);
    check_bytes("order_bgr", out1, e1);

    // Reset mid-pixel after the R byte.
    dat_rdy = 1'b0;
    push_pixel(24'h010203);
    dat_rdy = 1'b1;
    @(posedge clk);
    #1;
    dat_rdy = 1'b0;
    check("mid_ph1_dat", dat0, 8'h02);
    rst = 1'b1;
    #1;
    check("mid_rst_dat_vld", dv0, 0);
    check("mid_rst_dat_vld_bgr", dv1, 0);
    check("mid_rst_cnt", cnt0, 0);
    check("mid_rst_dat", dat0, 8'h00);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    clear_out();
    dat_rdy = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("mid_no_bytes", out0.size(), 0);
    push_pixel(24'h040506);
    check("mid_restart_dat", dat0, 8'h04);
    check("mid_restart_sop", sop0, 1);
    drain();
    e0 = '{8'h04, 8'h05, 8'h06};
`ifdef RGB_SERIALIZER_ALPHA_EN
    e0.push_back(8'hFF);
`endif
    check_bytes("mid_rgb", out0, e0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/rgb_serializer.md
Name: rgb_serializer

Overview:
- Sits directly downstream of the colour register stage and consumes its registered 8-bit r, g and b outputs.
- Buffers whole pixels in a small FIFO.
- Emits each pixel as a byte stream (R, G, B by default) over a valid/ready handshake, marking the first and last byte of each pixel.
- Decouples the one-pixel-per-cycle colour path from a byte-wide sink that may stall.

Parameters:
- DEPTH, 4, number of pixel entries in the FIFO; must be a power of 2 and at least 2.
- BGR, 0, byte order: 0 emits R,G,B; 1 emits B,G,R.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- r  input  8  red component of the input pixel.
- g  input  8  green component of the input pixel.
- b  input  8  blue component of the input pixel.
- vld  input  1  input pixel valid.
- rdy  output  1  input ready; a pixel transfers when vld && rdy at a rising clk.
- dat  output  8  output byte.
- dat_vld  output  1  output byte valid.
- dat_rdy  input  1  sink ready; a byte transfers when dat_vld && dat_rdy at a rising clk.
- dat_sop  output  1  dat is the first byte of a pixel.
- dat_eop  output  1  dat is the last byte of a pixel.
- cnt  output  $clog2(DEPTH)+1  number of pixels currently stored.

Behaviour:
Reset:
- While rst is high: write pointer, read pointer, cnt and byte phase are 0.
- While rst is high: rdy=0, dat_vld=0, dat_sop=0, dat_eop=0, dat=8'h00.
- The first write can occur at the first rising edge after rst falls.

FIFO:
- Entries are 24-bit {r,g,b}.
- rdy = (cnt != DEPTH) and not in reset; it is combinational from registered state.
- A write stores {r,g,b} at the write pointer and increments the pointer; the pointer wraps modulo DEPTH.
- When full, rdy stays 0 even if a pop occurs in the same cycle; there is no full pass-through.
- Push and pop in the same cycle leave cnt unchanged.

Output state machine:
- Byte phase: PH0 -> PH1 -> PH2 -> PH0.
- Phase advances only on a byte transfer.
- dat_vld = (cnt != 0).
- dat selects a byte of the head entry by phase:
  - BGR=0: PH0=R, PH1=G, PH2=B.
  - BGR=1: PH0=B, PH1=G, PH2=R.
- dat_sop = dat_vld && PH0.
- dat_eop = dat_vld && (last phase).
- A transfer in the last phase pops the head entry (read pointer +1, wrapping) and returns the phase to PH0.
- dat, dat_sop and dat_eop are combinational from registered state.
- When dat_vld=0, dat is held at 8'h00 and dat_sop/dat_eop are 0.

Latency and throughput:
- A pixel written at edge N makes its first byte visible in the cycle after N when the FIFO was empty.
- Sustained output throughput is 1 byte/cycle, i.e. one pixel per 3 cycles.
- The input therefore back-pressures once DEPTH pixels are queued.

Stall:
- While dat_vld && !dat_rdy, dat, dat_sop, dat_eop and the phase are held stable.

Reset mid-operation:
- Asserting rst mid-pixel discards all stored pixels and the partial pixel immediately; no further bytes are emitted.
- After release, output restarts at PH0 of the next written pixel.

cnt:
- Increments on a write, decrements on a pop, and is unchanged when both occur.
- Range 0..DEPTH.

Optional Feature:
Macro RGB_SERIALIZER_ALPHA_EN.
- When defined: a fourth phase PH3 emits a constant alpha byte 8'hFF after the three colour bytes.
- When defined: dat_eop marks PH3, the pop occurs on the PH3 transfer, and throughput is one pixel per 4 cycles.
- When not defined: 3-phase behaviour exactly as above, with no PH3 logic present.

Test Plan:
- Reset check: hold rst=1 with vld=1 -> rdy=0, dat_vld=0, cnt=0, and no bytes emitted after rst falls until a new write occurs.
- Single pixel: write {r,g,b}={8'h11,8'h22,8'h33}, dat_rdy=1 -> bytes 11,22,33 on consecutive cycles; sop on 11, eop on 33; cnt returns to 0.
- Ramp stream: write pixels i=0..15 with r=g=b=i, dat_rdy=1 -> 48 bytes in order; rdy deasserts when cnt=4 (DEPTH=4); pointer wrap exercised; no loss or duplication.
- Sink stall: dat_rdy=0 for 5 cycles mid-pixel while at PH1 -> dat held at the G byte with dat_vld=1; the full FIFO holds rdy=0; output resumes with the B byte.
- BGR=1 with pixel {8'hA0,8'hB0,8'hC0} -> bytes C0,B0,A0; with RGB_SERIALIZER_ALPHA_EN, bytes C0,B0,A0,FF with eop on FF.
- Reset mid-pixel: assert rst after the R byte of {01,02,03} -> dat_vld=0 immediately; after release, writing {04,05,06} emits 04,05,06 starting with sop.
